// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: walks one external 1-bit slice across a
// WIDTH-bit operation, LSB first, and assembles result and flags.
`timescale 1ns/1ps
module bit_serial_alu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_carryin,
   output logic [2:0]       slice_sel,
   output logic             slice_negate,
   input  logic             slice_out,
   input  logic             slice_carryout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_XOR  = 3'd6;
   localparam logic [2:0] OP_SLT  = 3'd7;

   localparam logic [2:0] SL_AND  = 3'd0;
   localparam logic [2:0] SL_NOR  = 3'd1;
   localparam logic [2:0] SL_OR   = 3'd2;
   localparam logic [2:0] SL_XOR  = 3'd3;
   localparam logic [2:0] SL_NAND = 3'd4;
   localparam logic [2:0] SL_ADD  = 3'd5;

   logic [0:0]       r_state;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-2:0] r_res_sh;
   logic [WIDTH-1:0] r_result;
   logic             r_carryout;
   logic             r_overflow;
   logic             r_zero;
   logic             r_done;

   logic             w_run;
   logic             w_arith;
   logic             w_neg;
   logic [2:0]       w_sel;
   logic             w_ovf;
   logic [WIDTH-1:0] w_cat;
   logic [WIDTH-1:0] w_final;
   logic             w_acc_sub;

   assign w_run = (r_state == S_RUN);

   always_comb begin
      w_arith = 1'b0;
      w_neg   = 1'b0;
      w_sel   = SL_AND;
      case (r_op)
         OP_ADD:  begin w_arith = 1'b1; w_sel = SL_ADD; end
         OP_SUB:  begin w_arith = 1'b1; w_neg = 1'b1; w_sel = SL_ADD; end
         OP_SLT:  begin w_arith = 1'b1; w_neg = 1'b1; w_sel = SL_ADD; end
         OP_AND:  w_sel = SL_AND;
         OP_NAND: w_sel = SL_NAND;
         OP_NOR:  w_sel = SL_NOR;
         OP_OR:   w_sel = SL_OR;
         OP_XOR:  w_sel = SL_XOR;
         default: w_sel = SL_AND;
      endcase
   end

   // Slice pins are parked at zero whenever no operation is running.
   assign slice_a       = w_run & r_a_sh[0];
   assign slice_b       = w_run & r_b_sh[0];
   assign slice_carryin = w_run & w_arith & r_carry;
   assign slice_negate  = w_run & w_neg;
   assign slice_sel     = w_run ? w_sel : 3'd0;

   assign w_ovf = w_arith & (slice_carryin ^ slice_carryout);
   assign w_cat = {slice_out, r_res_sh};

   always_comb begin
      w_final = w_cat;
      if (r_op == OP_SLT)
         w_final = {{(WIDTH-1){1'b0}}, slice_out ^ w_ovf};
   end

   assign w_acc_sub = (op == OP_SUB) || (op == OP_SLT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= 3'd0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_res_sh   <= '0;
         r_result   <= '0;
         r_carryout <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_op    <= op;
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_cnt   <= '0;
                  r_carry <= w_acc_sub;
               end
            end
            S_RUN: begin
               r_res_sh <= w_cat[WIDTH-1:1];
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_carry  <= slice_carryout;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_state    <= S_IDLE;
                  r_result   <= w_final;
                  r_carryout <= w_arith & slice_carryout;
                  r_overflow <= w_ovf;
                  r_zero     <= (w_final == '0);
                  r_done     <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = w_run;
   assign done     = r_done;
   assign result   = r_result;
   assign carryout = r_carryout;
   assign overflow = r_overflow;
   assign zero     = r_zero;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl (WIDTH=8) with a behavioural slice and
// an arithmetic reference model of every op.
`timescale 1ns/1ps
module tb_bit_serial_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] a = 8'd0;
   logic [7:0] b = 8'd0;
   logic       busy, done, carryout, overflow, zero;
   logic [7:0] result;
   logic       slice_a, slice_b, slice_carryin, slice_negate;
   logic [2:0] slice_sel;
   logic       slice_out, slice_carryout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bit_serial_alu_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carryout(carryout),
      .overflow(overflow), .zero(zero), .slice_a(slice_a),
      .slice_b(slice_b), .slice_carryin(slice_carryin),
      .slice_sel(slice_sel), .slice_negate(slice_negate),
      .slice_out(slice_out), .slice_carryout(slice_carryout)
   );

   // Behavioural 1-bit slice; carry is a full-adder carry for every select.
   logic w_bb;
   always_comb begin
      w_bb = slice_b ^ slice_negate;
      slice_carryout = (slice_a & w_bb) | (slice_a & slice_carryin)
                     | (w_bb & slice_carryin);
      case (slice_sel)
         3'd0: slice_out = slice_a & w_bb;
         3'd1: slice_out = ~(slice_a | w_bb);
         3'd2: slice_out = slice_a | w_bb;
         3'd3: slice_out = slice_a ^ w_bb;
         3'd4: slice_out = ~(slice_a & w_bb);
         3'd5: slice_out = slice_a ^ w_bb ^ slice_carryin;
         default: slice_out = 1'b0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_op(input logic [2:0] o,
                                  input logic [7:0] x, y,
                                  output logic [7:0] r,
                                  output logic co, ov);
      logic [8:0] s;
      int sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      co = 1'b0;
      ov = 1'b0;
      case (o)
         3'd0: begin
            s = {1'b0, x} + {1'b0, y};
            r = s[7:0]; co = s[8];
            ov = (sx + sy > 127) || (sx + sy < -128);
         end
         3'd1, 3'd7: begin
            s = {1'b0, x} + {1'b0, ~y} + 9'd1;
            r = s[7:0]; co = s[8];
            ov = (sx - sy > 127) || (sx - sy < -128);
            if (o == 3'd7) r = (sx < sy) ? 8'd1 : 8'd0;
         end
         3'd2: r = x & y;
         3'd3: r = ~(x & y);
         3'd4: r = ~(x | y);
         3'd5: r = x | y;
         default: r = x ^ y;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_op(input logic [2:0] o, input logic [7:0] x, y,
                         input int poke);
      logic [7:0] er, held;
      logic eco, eov;
      int lat;
      bit hold_bad, neg_bad;
      ref_op(o, x, y, er, eco, eov);
      held = result;
      hold_bad = 0;
      neg_bad = 0;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_run", {31'd0, busy}, 32'd1);
      lat = 0;
      while (lat < 20) begin
         if (slice_negate !== (o == 3'd1 || o == 3'd7)) neg_bad = 1;
         if (poke > 0 && lat == poke) begin
            start = 1'b1; op = 3'($urandom);
            a = 8'($urandom); b = 8'($urandom);
         end else start = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) break;
         if (result !== held) hold_bad = 1;
      end
      start = 1'b0;
      chk("latency", lat, 8);
      chk("result", {24'd0, result}, {24'd0, er});
      chk("carryout", {31'd0, carryout}, {31'd0, eco});
      chk("overflow", {31'd0, overflow}, {31'd0, eov});
      chk("zero", {31'd0, zero}, {31'd0, er == 8'd0});
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("negate", {31'd0, neg_bad}, 32'd0);
      chk("hold", {31'd0, hold_bad}, 32'd0);
   endtask

   initial begin
      bit nd;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_flags", {29'd0, carryout, overflow, zero}, 32'd0);
      chk("rst_slice", {25'd0, slice_a, slice_b, slice_carryin,
          slice_negate, slice_sel}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3'd0, 8'h7F, 8'h01, 0);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      run_op(3'd1, 8'h05, 8'h05, 0);
      run_op(3'd7, 8'h80, 8'h01, 0);
      run_op(3'd7, 8'h01, 8'h80, 0);
      run_op(3'd6, 8'hF0, 8'h3C, 0);
      run_op(3'd3, 8'hFF, 8'h0F, 0);
      run_op(3'd4, 8'h00, 8'h00, 0);
      @(negedge clk);
      run_op(3'd0, 8'h12, 8'h34, 3);
      run_op(3'd2, 8'hA5, 8'h0F, 5);

      // Abort in the middle of an op.
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", {24'd0, result}, 32'd0);
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) nd = 1;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) nd = 1;
      end
      chk("abort_nodone", {31'd0, nd}, 32'd0);
      run_op(3'd1, 8'h40, 8'h41, 0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
